// File: rtl/seq_fsm_preamble_101_tx.sv
// Serial frame transmitter for the "101" sequence-detect link.
// A word accepted over valid/ready is sent as preamble 1,0,1, then the payload
// MSB-first, then a single 0 gap bit that keeps back-to-back preambles distinct.
// out/out_valid are registered from the next-state values, so they describe the
// registered state with no combinational path from in_* to the serial line.
module seq_fsm_preamble_101_tx #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    output logic [1:0]       state,
    output logic             out,
    output logic             out_valid
);

    // Counter covers both the 3 preamble bits and the NBITS payload bits.
    localparam int CW = $clog2((NBITS > 3) ? NBITS : 3);

    localparam logic [CW-1:0] CNT_ZERO      = CW'(0);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_PRE_LAST  = CW'(2);
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;

    // Next-state, counter and shift-register update for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_PRE;
                    cnt_d   = CNT_ZERO;
                    shreg_d = in_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == CNT_PRE_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_DATA_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    shreg_d = shreg_q << 1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                shreg_d = '0;
            end
        endcase
    end

    // Line value and valid flag for the state being entered, so the flops hold them.
    always_comb begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                out_d       = 1'b0;
                out_valid_d = 1'b0;
            end
            S_PRE: begin
                out_d       = (cnt_d != CNT_ONE);
                out_valid_d = 1'b1;
            end
            S_DATA: begin
                out_d       = shreg_d[NBITS-1];
                out_valid_d = 1'b1;
            end
            S_GAP: begin
                out_d       = 1'b0;
                out_valid_d = 1'b0;
            end
            default: begin
                out_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            shreg_q     <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is handshaken then.
    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign state     = state_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_fsm_preamble_101_tx.sv
// Bench for seq_fsm_preamble_101_tx: an 8-bit and a 1-bit instance share stimulus.
// A frame-level reference model builds each expected frame as a list of
// per-cycle (out, out_valid, state) records; those are queued and a monitor
// pops and compares one record per cycle after each rising edge.
module tb_seq_fsm_preamble_101_tx;

    typedef struct packed {
        logic       o;
        logic       v;
        logic [1:0] st;
    } ent_t;
    typedef ent_t ent_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready8, out8, out_valid8;
    logic [1:0] state8;
    logic       in_ready1, out1, out_valid1;
    logic [1:0] state1;
    logic [0:0] in_data1;

    int vectors = 0;
    int miscompares = 0;

    ent_q_t cur8, cur1;   // remaining cycles of the frame each model is showing
    ent_q_t sb8, sb1;     // expected records awaiting the monitor
    logic   obs8, obs1, obs_ready8;

    assign in_data1 = in_data[0:0];

    always #5 clk = ~clk;

    seq_fsm_preamble_101_tx #(.NBITS(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .state(state8), .out(out8), .out_valid(out_valid8)
    );

    seq_fsm_preamble_101_tx #(.NBITS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data1), .state(state1), .out(out1), .out_valid(out_valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One frame: preamble 1,0,1 (state PRE), n payload bits MSB-first, one gap bit.
    function automatic ent_q_t make_frame(input int n, input logic [31:0] d);
        ent_q_t f;
        ent_t   e;
        for (int i = 0; i < 3; i++) begin
            e.o = (i != 1); e.v = 1'b1; e.st = 2'd1;
            f.push_back(e);
        end
        for (int i = n - 1; i >= 0; i--) begin
            e.o = d[i]; e.v = 1'b1; e.st = 2'd2;
            f.push_back(e);
        end
        e.o = 1'b0; e.v = 1'b0; e.st = 2'd3;
        f.push_back(e);
        return f;
    endfunction

    function automatic ent_t idle_ent();
        ent_t e;
        e.o = 1'b0; e.v = 1'b0; e.st = 2'd0;
        return e;
    endfunction

    // Advance both models across one rising edge and queue what each should show.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        if (r) begin
            cur8.delete();
            cur1.delete();
        end else begin
            if (cur8.size() == 0) begin
                if (v) cur8 = make_frame(8, {24'h000000, d});
            end else begin
                void'(cur8.pop_front());
            end
            if (cur1.size() == 0) begin
                if (v) cur1 = make_frame(1, {31'h00000000, d[0]});
            end else begin
                void'(cur1.pop_front());
            end
        end
        sb8.push_back((cur8.size() != 0) ? cur8[0] : idle_ent());
        sb1.push_back((cur1.size() != 0) ? cur1[0] : idle_ent());
    endtask

    // Drive one cycle of inputs on the falling edge, check ready, predict the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        obs8       = out8;
        obs1       = out1;
        obs_ready8 = in_ready8;
        in_valid   = v;
        in_data    = d;
        reset      = r;
        #1;
        chk("in_ready8", {31'd0, in_ready8}, {31'd0, (cur8.size() == 0) && !r});
        chk("in_ready1", {31'd0, in_ready1}, {31'd0, (cur1.size() == 0) && !r});
        model_edge(v, d, r);
    endtask

    // Monitor: compare the registered outputs against the queued expectation.
    always begin
        ent_t e;
        @(posedge clk);
        #1;
        if (sb8.size() != 0) begin
            e = sb8.pop_front();
            chk("out8", {31'd0, out8}, {31'd0, e.o});
            chk("out_valid8", {31'd0, out_valid8}, {31'd0, e.v});
            chk("state8", {30'd0, state8}, {30'd0, e.st});
        end
        if (sb1.size() != 0) begin
            e = sb1.pop_front();
            chk("out1", {31'd0, out1}, {31'd0, e.o});
            chk("out_valid1", {31'd0, out_valid1}, {31'd0, e.v});
            chk("state1", {30'd0, state1}, {30'd0, e.st});
        end
    end

    initial begin
        logic [11:0] got8;
        logic [4:0]  got1;
        int          lows;

        // Reset for a few cycles.
        repeat (3) step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Single frame of 8'hA5; the 1-bit instance sends bit 1.
        step(1'b1, 8'hA5, 1'b0);
        got8 = '0;
        got1 = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h00, 1'b0);
            got8 = {got8[10:0], obs8};
            if (i < 5) got1 = {got1[3:0], obs1};
        end
        chk("a5_serial", {20'd0, got8}, 32'h00000B4A);
        chk("nbits1_serial", {27'd0, got1}, 32'h00000016);

        // Valid held high: FF frame, one ready cycle, then the 00 frame.
        step(1'b1, 8'hFF, 1'b0);
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            if (!obs_ready8) lows++;
        end
        chk("busy_cycles", lows, 32'd12);
        step(1'b1, 8'h00, 1'b0);
        chk("ready_after_frame", {31'd0, obs_ready8}, 32'd1);

        // New data offered mid-frame is ignored.
        for (int i = 0; i < 12; i++) step(1'b1, 8'h3C ^ 8'(i), 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0);

        // Reset on the third payload cycle, then a clean frame.
        step(1'b1, 8'hC3, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h96, 1'b0);
        repeat (13) step(1'b0, 8'h00, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 24) == 0));
        end
        repeat (14) step(1'b0, 8'h00, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
